// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, datapath
// select codes, ALU operations and condition codes.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_MULEX  = 4'd10,
      S_MULWB  = 4'd11
   } state_t;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b010;
   localparam logic [2:0] ALU_ORR   = 3'b011;
   localparam logic [2:0] ALU_MUL   = 3'b100;
   localparam logic [2:0] ALU_UMULL = 3'b101;
   localparam logic [2:0] ALU_SMULL = 3'b110;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_REG = 2'b00;
   localparam logic [1:0] SRCA_PC  = 2'b01;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_8   = 2'b00;
   localparam logic [1:0] IMM_12  = 2'b01;
   localparam logic [1:0] IMM_BR  = 2'b10;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   // nzcv ordered {N,Z,C,V}; 1111 never executes
   function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v, res;
      {n, z, c, v} = nzcv;
      case (cond)
         COND_EQ: res = z;
         COND_NE: res = ~z;
         COND_CS: res = c;
         COND_CC: res = ~c;
         COND_MI: res = n;
         COND_PL: res = ~n;
         COND_VS: res = v;
         COND_VC: res = ~v;
         COND_HI: res = c & ~z;
         COND_LS: res = ~c | z;
         COND_GE: res = (n == v);
         COND_LT: res = (n != v);
         COND_GT: res = ~z & (n == v);
         COND_LE: res = z | (n != v);
         COND_AL: res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: instruction/flags in, selects and enables out.
// master = control unit side, slave = datapath side.
interface mc_controller_if;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite;
   logic        MemWrite;
   logic        RegWrite;
   logic        IRWrite;
   logic        AdrSrc;
   logic [1:0]  RegSrc;
   logic [1:0]  ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ResultSrc;
   logic [1:0]  ImmSrc;
   logic [2:0]  ALUControl;
   logic        RegSrc64b;
   logic        Sel64b;

   modport master (
      input  Instr, ALUFlags,
      output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, RegSrc64b, Sel64b
   );

   modport slave (
      output Instr, ALUFlags,
      input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, RegSrc64b, Sel64b
   );
endinterface

// File: rtl/condlogic.sv
// NZCV flags register and condition evaluation. Flag writes are requested by
// the FSM and only land when the instruction's condition holds.
module condlogic (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond_i,
   input  logic [3:0] alu_flags_i,
   input  logic       flag_wr_nz_i,
   input  logic       flag_wr_cv_i,
   output logic       cond_ex_o
);
   import ctrl_pkg::*;

   logic [3:0] flags_q;
   logic [3:0] flags_d;

   assign cond_ex_o = cond_holds(cond_i, flags_q);

   always_comb begin
      flags_d = flags_q;
      if (cond_ex_o && flag_wr_nz_i) flags_d[3:2] = alu_flags_i[3:2];
      if (cond_ex_o && flag_wr_cv_i) flags_d[1:0] = alu_flags_i[1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) flags_q <= 4'b0000;
      else        flags_q <= flags_d;
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control unit with 32/64-bit multiply. Define MULL_EN to
// enable UMULL/SMULL; otherwise long-multiply encodings decode as undefined.
//
// state  | meaning
// FETCH  | load IR, PC <= PC+4
// DECODE | read registers, classify instruction
// MEMADR | compute load/store address
// MEMRD  | read memory at computed address
// MEMWB  | write loaded data to register file
// MEMWR  | write register to memory
// EXECR  | data-processing, register operand
// EXECI  | data-processing, immediate operand
// ALUWB  | write ALU result (to PC when Rd is R15)
// BRANCH | PC <= PC+8+offset if condition holds
// MULEX  | multiply with remapped register fields
// MULWB  | write 32-bit product or 64-bit {RdHi,RdLo}
module mc_controller (
   input logic            clk,
   input logic            reset,
   mc_controller_if.master bus
);
   import ctrl_pkg::*;

   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] cond;
   logic       is_mul;
   logic       mul_ok;
   logic [2:0] dp_alu_ctl;
   logic [2:0] mul_alu_ctl;
   logic       cond_ex;
   logic       flag_wr_nz;
   logic       flag_wr_cv;
   logic       unused_instr;

   state_t     state_q, state_d;
   logic       pc_wr_fetch_q;
   logic       pc_wr_cond_q;
   logic       ir_write_q;
   logic       reg_write_q;
   logic       mem_write_q;
   logic       adr_src_q;
   logic [1:0] alu_src_a_q;
   logic [1:0] alu_src_b_q;
   logic [1:0] result_src_q;
   logic [2:0] alu_ctl_q;
   logic       reg_src_64b_q;

   assign op    = bus.Instr[27:26];
   assign funct = bus.Instr[25:20];
   assign rd    = bus.Instr[15:12];
   assign cond  = bus.Instr[31:28];

   assign unused_instr = ^{bus.Instr[19:16], bus.Instr[11:8], bus.Instr[3:0]};

   assign is_mul = (op == 2'b00) && (bus.Instr[25:24] == 2'b00) && (bus.Instr[7:4] == 4'b1001);

`ifdef MULL_EN
   logic sel_64b_q;
   assign mul_ok      = is_mul;
   assign mul_alu_ctl = bus.Instr[23] ? (bus.Instr[22] ? ALU_SMULL : ALU_UMULL) : ALU_MUL;
   assign bus.Sel64b  = sel_64b_q;
`else
   assign mul_ok      = is_mul & ~bus.Instr[23];
   assign mul_alu_ctl = ALU_MUL;
   assign bus.Sel64b  = 1'b0;
`endif

   always_comb begin
      case (funct[4:1])
         4'b0100: dp_alu_ctl = ALU_ADD;
         4'b0010: dp_alu_ctl = ALU_SUB;
         4'b0000: dp_alu_ctl = ALU_AND;
         4'b1100: dp_alu_ctl = ALU_ORR;
         default: dp_alu_ctl = ALU_ADD;
      endcase
   end

   always_comb begin
      case (op)
         2'b00:   bus.ImmSrc = IMM_8;
         2'b01:   bus.ImmSrc = IMM_12;
         2'b10:   bus.ImmSrc = IMM_BR;
         default: bus.ImmSrc = IMM_8;
      endcase
      case (op)
         2'b01:   bus.RegSrc = 2'b10;
         2'b10:   bus.RegSrc = 2'b01;
         default: bus.RegSrc = 2'b00;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            if (is_mul)           state_d = mul_ok ? S_MULEX : S_FETCH;
            else if (op == 2'b00) state_d = funct[5] ? S_EXECI : S_EXECR;
            else if (op == 2'b01) state_d = S_MEMADR;
            else if (op == 2'b10) state_d = S_BRANCH;
            else                  state_d = S_FETCH;
         end
         S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = S_MEMWB;
         S_EXECR:  state_d = S_ALUWB;
         S_EXECI:  state_d = S_ALUWB;
         S_MULEX:  state_d = S_MULWB;
         default:  state_d = S_FETCH;
      endcase
   end

   // Outputs are registered from the next state; only CondEx gating is combinational.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_FETCH;
         pc_wr_fetch_q <= 1'b1;
         ir_write_q    <= 1'b1;
         pc_wr_cond_q  <= 1'b0;
         reg_write_q   <= 1'b0;
         mem_write_q   <= 1'b0;
         adr_src_q     <= 1'b0;
         alu_src_a_q   <= SRCA_PC;
         alu_src_b_q   <= SRCB_FOUR;
         result_src_q  <= RES_ALURESULT;
         alu_ctl_q     <= ALU_ADD;
         reg_src_64b_q <= 1'b0;
`ifdef MULL_EN
         sel_64b_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         pc_wr_fetch_q <= 1'b0;
         ir_write_q    <= 1'b0;
         pc_wr_cond_q  <= 1'b0;
         reg_write_q   <= 1'b0;
         mem_write_q   <= 1'b0;
         adr_src_q     <= 1'b0;
         alu_src_a_q   <= SRCA_REG;
         alu_src_b_q   <= SRCB_REG;
         result_src_q  <= RES_ALUOUT;
         alu_ctl_q     <= ALU_ADD;
         reg_src_64b_q <= 1'b0;
`ifdef MULL_EN
         sel_64b_q     <= 1'b0;
`endif
         case (state_d)
            S_FETCH: begin
               pc_wr_fetch_q <= 1'b1;
               ir_write_q    <= 1'b1;
               alu_src_a_q   <= SRCA_PC;
               alu_src_b_q   <= SRCB_FOUR;
               result_src_q  <= RES_ALURESULT;
            end
            S_DECODE: begin
               alu_src_a_q  <= SRCA_PC;
               alu_src_b_q  <= SRCB_FOUR;
               result_src_q <= RES_ALURESULT;
            end
            S_MEMADR: alu_src_b_q <= SRCB_IMM;
            S_MEMRD:  adr_src_q   <= 1'b1;
            S_MEMWB: begin
               result_src_q <= RES_DATA;
               reg_write_q  <= 1'b1;
            end
            S_MEMWR: begin
               adr_src_q   <= 1'b1;
               mem_write_q <= 1'b1;
            end
            S_EXECR: alu_ctl_q <= dp_alu_ctl;
            S_EXECI: begin
               alu_src_b_q <= SRCB_IMM;
               alu_ctl_q   <= dp_alu_ctl;
            end
            S_ALUWB: begin
               reg_write_q  <= 1'b1;
               pc_wr_cond_q <= (rd == 4'd15);
            end
            S_BRANCH: begin
               alu_src_b_q  <= SRCB_IMM;
               result_src_q <= RES_ALURESULT;
               pc_wr_cond_q <= 1'b1;
            end
            S_MULEX: begin
               reg_src_64b_q <= 1'b1;
               alu_ctl_q     <= mul_alu_ctl;
            end
            S_MULWB: begin
               reg_src_64b_q <= 1'b1;
               reg_write_q   <= 1'b1;
`ifdef MULL_EN
               sel_64b_q     <= bus.Instr[23];
`endif
            end
            default: ;
         endcase
      end
   end

   assign flag_wr_nz = ((state_q == S_EXECR) || (state_q == S_EXECI) || (state_q == S_MULEX))
                       && funct[0];
   assign flag_wr_cv = flag_wr_nz && ((alu_ctl_q == ALU_ADD) || (alu_ctl_q == ALU_SUB));

   condlogic u_cond (
      .clk          (clk),
      .reset        (reset),
      .cond_i       (cond),
      .alu_flags_i  (bus.ALUFlags),
      .flag_wr_nz_i (flag_wr_nz),
      .flag_wr_cv_i (flag_wr_cv),
      .cond_ex_o    (cond_ex)
   );

   // Enables are held off combinationally while reset is low so nothing is written.
   assign bus.PCWrite    = reset & (pc_wr_fetch_q | (pc_wr_cond_q & cond_ex));
   assign bus.IRWrite    = reset & ir_write_q;
   assign bus.RegWrite   = reset & reg_write_q & cond_ex;
   assign bus.MemWrite   = reset & mem_write_q & cond_ex;
   assign bus.AdrSrc     = adr_src_q;
   assign bus.ALUSrcA    = alu_src_a_q;
   assign bus.ALUSrcB    = alu_src_b_q;
   assign bus.ResultSrc  = result_src_q;
   assign bus.ALUControl = alu_ctl_q;
   assign bus.RegSrc64b  = reg_src_64b_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller; long-multiply checks follow MULL_EN.
module tb_mc_controller;
   import ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_total = 0;
   int   n_bad   = 0;

   mc_controller_if bus ();

   mc_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", n_total, n_bad);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic st(input string tag, input state_t exp);
      tick();
      chk(tag, 32'(dut.state_q), 32'(exp));
   endtask

   // Data-processing register form: FETCH, DECODE, EXECR, ALUWB, FETCH
   task automatic run_alu(input string tag, input logic [31:0] instr, input logic [2:0] ctl,
                          input logic rw, input logic pcw);
      bus.Instr = instr;
      st({tag, "_dec"}, S_DECODE);
      st({tag, "_ex"}, S_EXECR);
      chk({tag, "_ctl"}, 32'(bus.ALUControl), 32'(ctl));
      st({tag, "_wb"}, S_ALUWB);
      chk({tag, "_rw"}, 32'(bus.RegWrite), 32'(rw));
      chk({tag, "_pcw"}, 32'(bus.PCWrite), 32'(pcw));
      st({tag, "_end"}, S_FETCH);
   endtask

   initial begin
      reset        = 1'b0;
      bus.Instr    = 32'h0;
      bus.ALUFlags = 4'b0000;

      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_we", 32'({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite}), 0);
      end
      chk("rst_state", 32'(dut.state_q), 32'(S_FETCH));
      chk("rst_srcb", 32'(bus.ALUSrcB), 'b10);
      chk("rst_srca", 32'(bus.ALUSrcA), 'b01);

      reset = 1'b1;
      #1;
      chk("fetch_pcw", 32'(bus.PCWrite), 1);
      chk("fetch_irw", 32'(bus.IRWrite), 1);

      // BEQ with Z=0: not taken
      bus.Instr = 32'h0A000002;
      #1;
      chk("beq_imm", 32'(bus.ImmSrc), 'b10);
      chk("beq_regsrc", 32'(bus.RegSrc), 'b01);
      st("beq0_dec", S_DECODE);
      chk("beq0_dec_pcw", 32'(bus.PCWrite), 0);
      st("beq0_br", S_BRANCH);
      chk("beq0_pcw", 32'(bus.PCWrite), 0);
      chk("beq0_srcb", 32'(bus.ALUSrcB), 'b01);
      st("beq0_end", S_FETCH);

      // ADDS R1,R2,#5 with Z result -> flags 0100
      bus.Instr    = 32'hE2921005;
      bus.ALUFlags = 4'b0100;
      st("adds_dec", S_DECODE);
      st("adds_ex", S_EXECI);
      chk("adds_srcb", 32'(bus.ALUSrcB), 'b01);
      chk("adds_ctl", 32'(bus.ALUControl), 'b000);
      st("adds_wb", S_ALUWB);
      chk("adds_rw", 32'(bus.RegWrite), 1);
      chk("adds_pcw", 32'(bus.PCWrite), 0);
      chk("adds_res", 32'(bus.ResultSrc), 'b00);
      st("adds_end", S_FETCH);
      bus.ALUFlags = 4'b0000;

      // BEQ with Z=1: taken
      bus.Instr = 32'h0A000002;
      st("beq1_dec", S_DECODE);
      st("beq1_br", S_BRANCH);
      chk("beq1_pcw", 32'(bus.PCWrite), 1);
      st("beq1_end", S_FETCH);

      // LDR R0,[R1,#8]: five cycles
      bus.Instr = 32'hE5910008;
      st("ldr_dec", S_DECODE);
      st("ldr_adr", S_MEMADR);
      chk("ldr_adr_srcb", 32'(bus.ALUSrcB), 'b01);
      st("ldr_rd", S_MEMRD);
      chk("ldr_rd_adrsrc", 32'(bus.AdrSrc), 1);
      chk("ldr_rd_res", 32'(bus.ResultSrc), 'b00);
      st("ldr_wb", S_MEMWB);
      chk("ldr_wb_res", 32'(bus.ResultSrc), 'b01);
      chk("ldr_wb_rw", 32'(bus.RegWrite), 1);
      st("ldr_end", S_FETCH);

      // UMULL
      bus.Instr = 32'hE0810392;
      st("umull_dec", S_DECODE);
`ifdef MULL_EN
      st("umull_ex", S_MULEX);
      chk("umull_ex_r64", 32'(bus.RegSrc64b), 1);
      chk("umull_ctl", 32'(bus.ALUControl), 'b101);
      st("umull_wb", S_MULWB);
      chk("umull_wb_bits", 32'({bus.RegSrc64b, bus.Sel64b, bus.RegWrite}), 'b111);
      st("umull_end", S_FETCH);

      bus.Instr = 32'hE0C10392;
      st("smull_dec", S_DECODE);
      st("smull_ex", S_MULEX);
      chk("smull_ctl", 32'(bus.ALUControl), 'b110);
      st("smull_wb", S_MULWB);
      chk("smull_sel", 32'(bus.Sel64b), 1);
      st("smull_end", S_FETCH);
`else
      chk("umull_dec_we", 32'({bus.RegWrite, bus.MemWrite}), 0);
      st("umull_undef", S_FETCH);
      chk("umull_undef_we", 32'({bus.RegWrite, bus.MemWrite, bus.Sel64b}), 0);
`endif

      // 32-bit MUL
      bus.Instr = 32'hE0010392;
      st("mul_dec", S_DECODE);
      st("mul_ex", S_MULEX);
      chk("mul_ctl", 32'(bus.ALUControl), 'b100);
      chk("mul_r64", 32'(bus.RegSrc64b), 1);
      st("mul_wb", S_MULWB);
      chk("mul_wb_bits", 32'({bus.RegSrc64b, bus.Sel64b, bus.RegWrite}), 'b101);
      st("mul_end", S_FETCH);

      // ORRS updates NZ only: flags 0100 -> 1000 with ALUFlags 1011
      bus.ALUFlags = 4'b1011;
      run_alu("orrs", 32'hE1900001, ALU_ORR, 1'b1, 1'b0);
      bus.ALUFlags = 4'b0000;
      run_alu("addmi", 32'h40822003, ALU_ADD, 1'b1, 1'b0);
      run_alu("addcs", 32'h20822003, ALU_ADD, 1'b0, 1'b0);
      run_alu("addlt", 32'hB0822003, ALU_ADD, 1'b1, 1'b0);
      run_alu("sub", 32'hE0422003, ALU_SUB, 1'b1, 1'b0);
      run_alu("and", 32'hE0022003, ALU_AND, 1'b1, 1'b0);
      run_alu("eor_dflt", 32'hE0222003, ALU_ADD, 1'b1, 1'b0);
      run_alu("add_pc", 32'hE082F003, ALU_ADD, 1'b1, 1'b1);

      // Undefined Op=11: two cycles, no writes
      bus.Instr = 32'hEC000000;
      st("undef_dec", S_DECODE);
      chk("undef_we", 32'({bus.RegWrite, bus.MemWrite, bus.PCWrite}), 0);
      st("undef_end", S_FETCH);

      // STR completes
      bus.Instr = 32'hE5810008;
      st("str_dec", S_DECODE);
      st("str_adr", S_MEMADR);
      st("str_wr", S_MEMWR);
      chk("str_mw", 32'(bus.MemWrite), 1);
      chk("str_adrsrc", 32'(bus.AdrSrc), 1);
      st("str_end", S_FETCH);

      // STR aborted by reset in MEMWR
      st("strr_dec", S_DECODE);
      st("strr_adr", S_MEMADR);
      st("strr_wr", S_MEMWR);
      reset = 1'b0;
      #1;
      chk("strr_mw", 32'(bus.MemWrite), 0);
      chk("strr_state", 32'(dut.state_q), 32'(S_FETCH));
      tick();
      chk("strr_hold_we", 32'({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite}), 0);
      reset = 1'b1;
      #1;
      chk("strr_rel_irw", 32'(bus.IRWrite), 1);

      // BMI after reset: flags cleared, not taken
      bus.Instr = 32'h4A000002;
      st("bmi_dec", S_DECODE);
      st("bmi_br", S_BRANCH);
      chk("bmi_pcw", 32'(bus.PCWrite), 0);
      st("bmi_end", S_FETCH);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
